pipe_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage pipeline. It freezes or bubbles PC, IF/ID, ID/EX, EX/MEM and MEM/WB through their stall/flush inputs. It detects load-use hazards and sequences multi-cycle data-memory accesses through a req/ack handshake, with a timeout. It also handles taken-branch flushes and keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/pipe_hazard_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller with load-use, data-memory wait and branch flush
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             branch_taken_i,
  input  logic             exmem_memread_i,
  input  logic             exmem_memwrite_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             idex_stall_o,
  output logic             exmem_stall_o,
  output logic             memwb_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_nxt;
  logic             access;
  logic             mem_busy;
  logic             load_use;

  assign access   = exmem_memread_i | exmem_memwrite_i;
  assign mem_busy = ((state == IDLE) & access) | (state == MEM_WAIT);
  assign load_use = idex_memread_i & (idex_rt_i != 5'd0) &
                    ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
  assign wait_nxt = wait_cnt + CNT_W'(1);

  always_comb begin
    pc_stall_o    = 1'b0;
    ifid_stall_o  = 1'b0;
    idex_stall_o  = 1'b0;
    exmem_stall_o = 1'b0;
    memwb_stall_o = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    if (!rst_i) begin
      if (mem_busy) begin
        pc_stall_o    = 1'b1;
        ifid_stall_o  = 1'b1;
        idex_stall_o  = 1'b1;
        exmem_stall_o = 1'b1;
        memwb_stall_o = 1'b1;
      end else if (load_use) begin
        // the branch sitting in ID must survive the bubble, so no IF/ID flush here
        pc_stall_o    = 1'b1;
        ifid_stall_o  = 1'b1;
        idex_flush_o  = 1'b1;
      end else if (branch_taken_i) begin
        ifid_flush_o  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      mem_req_o     <= 1'b0;
      mem_timeout_o <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            state     <= MEM_WAIT;
            mem_req_o <= 1'b1;
            wait_cnt  <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ack_i) begin
            state     <= MEM_DONE;
            mem_req_o <= 1'b0;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_LAST) begin
              state         <= MEM_DONE;
              mem_req_o     <= 1'b0;
              mem_timeout_o <= 1'b1;
            end
          end
        end
        // access inputs still belong to the instruction just served
        MEM_DONE: state <= IDLE;
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_o <= '0;
    end else if (pc_stall_o && (stall_cycles_o != {CNT_W{1'b1}})) begin
      stall_cycles_o <= stall_cycles_o + CNT_W'(1);
    end
  end

endmodule
